// File: rtl/leg_call_stack_if.sv
// Storage interface of the return-address stack: CALL/RET strobes in,
// registered top-of-stack, occupancy and sticky error flags out.
interface leg_call_stack_if #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH + 1)
);
    // push/pop/clr_err are single-cycle strobes with no back-pressure: each is
    // acted on at the edge where it is high, and the stack never stalls the core.
    logic             push;
    logic [WIDTH-1:0] push_data;
    logic             pop;
    logic             clr_err;
    logic [WIDTH-1:0] top;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, push_data, pop, clr_err,
        input  top, empty, full, count, overflow, underflow
    );

    modport slave (
        input  push, push_data, pop, clr_err,
        output top, empty, full, count, overflow, underflow
    );
endinterface

// File: rtl/leg_call_stack.sv
// Hardware return-address stack for CALL/RET: registered top, occupancy count,
// sticky overflow/underflow flags; push+pop together replaces the top entry.
module leg_call_stack #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input logic           clk,
    input logic           rst,
    leg_call_stack_if.slave bus
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] top_q;
    logic             overflow_q;
    logic             underflow_q;

    logic             is_empty;
    logic             is_full;
    logic [CW-1:0]    cnt_m1;
    logic [CW-1:0]    cnt_m2;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] below_top;

    always_comb begin
        is_empty  = (count_q == '0);
        is_full   = (count_q == CW'(DEPTH));
        cnt_m1    = count_q - CW'(1);
        cnt_m2    = count_q - CW'(2);
        below_top = mem[cnt_m2[AW-1:0]];
        wr_en     = 1'b0;
        wr_addr   = count_q[AW-1:0];
        if (bus.push) begin
            if (bus.pop && !is_empty) begin
                // tail-call: overwrite the current top slot in place
                wr_en   = 1'b1;
                wr_addr = cnt_m1[AW-1:0];
            end else if (bus.pop || !is_full) begin
                wr_en   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_addr] <= bus.push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            top_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            // clear first so a same-cycle error event below wins
            if (bus.clr_err) begin
                overflow_q  <= 1'b0;
                underflow_q <= 1'b0;
            end
            case ({bus.push, bus.pop})
                2'b10: begin
                    if (!is_full) begin
                        count_q <= count_q + CW'(1);
                        top_q   <= bus.push_data;
                    end else begin
                        overflow_q <= 1'b1;
                    end
                end
                2'b01: begin
                    if (!is_empty) begin
                        count_q <= cnt_m1;
                        top_q   <= (count_q == CW'(1)) ? '0 : below_top;
                    end else begin
                        underflow_q <= 1'b1;
                    end
                end
                2'b11: begin
                    top_q <= bus.push_data;
                    if (is_empty) begin
                        count_q <= CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.top       = top_q;
    assign bus.count     = count_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule
